// File: rtl/cpu_pkg.sv
// Shared CPU types and constants.
// Used by the fetch stage and its next-PC mux.
package cpu_pkg;

    localparam int PC_W    = 8;
    localparam int INSTR_W = 16;
    localparam int CNT_W   = 16;

    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 12;

    localparam logic [PC_W-1:0]    RESET_PC  = 8'h00;
    localparam logic [PC_W-1:0]    PC_ONE    = 8'h01;
    localparam logic [3:0]         HALT_OPC  = 4'hF;
    localparam logic [INSTR_W-1:0] NOP_INSTR = 16'h0000;
    localparam logic [CNT_W-1:0]   CNT_MAX   = 16'hFFFF;
    localparam logic [CNT_W-1:0]   CNT_ONE   = 16'h0001;

    typedef enum logic {
        FS_RUN,
        FS_HALTED
    } fetch_state_t;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [PC_W-1:0]    pc_plus_1;
        logic               valid;
    } if_id_t;

    function automatic logic is_halt(input logic [INSTR_W-1:0] instr);
        return instr[OPC_MSB:OPC_LSB] == HALT_OPC;
    endfunction

endpackage

// File: rtl/if_pc_sel.sv
// Next-PC priority mux for the fetch stage.
// Order: reset, redirect, hold, increment.
module if_pc_sel
    import cpu_pkg::*;
(
    input  logic            reset,
    input  logic            redirect_valid,
    input  logic [PC_W-1:0] redirect_target,
    input  logic            hold,
    input  logic [PC_W-1:0] pc,
    output logic [PC_W-1:0] pc_next
);

    logic sel_reset;
    logic sel_redir;
    logic sel_hold;
    logic sel_inc;

    // One-hot selects so the decoder below is truly unique.
    assign sel_reset = reset;
    assign sel_redir = !reset && redirect_valid;
    assign sel_hold  = !reset && !redirect_valid && hold;
    assign sel_inc   = !reset && !redirect_valid && !hold;

    always_comb begin
        pc_next = pc;
        unique case (1'b1)
            sel_reset: pc_next = RESET_PC;
            sel_redir: pc_next = redirect_target;
            sel_hold:  pc_next = pc;
            sel_inc:   pc_next = pc + PC_ONE;
            default:   pc_next = pc;
        endcase
    end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC, fetch FSM, HALT detect,
// wrong-path squash and a saturating fetch counter.
module if_fetch_stage
    import cpu_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               stall,
    input  logic               redirect_valid,
    input  logic [PC_W-1:0]    redirect_target,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] IF_instruction,
    output logic [PC_W-1:0]    IF_PC_plus_1,
    output logic               IF_valid,
    output logic               halted,
    output logic [CNT_W-1:0]   fetch_count
);

    logic [PC_W-1:0]  pc;
    logic [PC_W-1:0]  pc_next;
    fetch_state_t     state;
    logic [CNT_W-1:0] cnt;
    logic             running;
    logic             advance;
    logic             hold;
    if_id_t           if_out;

    assign running = (state == FS_RUN);
    assign advance = running && !stall && !redirect_valid;
    assign hold    = !running || stall;

    if_pc_sel u_pc_sel (
        .reset           (reset),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .hold            (hold),
        .pc              (pc),
        .pc_next         (pc_next)
    );

    always_ff @(posedge clk) begin
        pc <= pc_next;
    end

    // HALT is only taken on an advancing fetch; a stalled or
    // squashed HALT word must not stop the machine.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= FS_RUN;
        end else if (redirect_valid) begin
            state <= FS_RUN;
        end else if (advance && is_halt(imem_rdata)) begin
            state <= FS_HALTED;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (advance && cnt != CNT_MAX) begin
            cnt <= cnt + CNT_ONE;
        end
    end

    always_comb begin
        if_out.valid     = !reset && running && !redirect_valid;
        if_out.pc_plus_1 = pc + PC_ONE;
        if_out.instr     = if_out.valid ? imem_rdata : NOP_INSTR;
    end

    assign imem_addr      = pc;
    assign IF_instruction = if_out.instr;
    assign IF_PC_plus_1   = if_out.pc_plus_1;
    assign IF_valid       = if_out.valid;
    assign halted         = !reset && (state == FS_HALTED);
    assign fetch_count    = cnt;

endmodule
